// File: rtl/fetch_decode_ctrl_if.sv
// Bus between fetch_decode_ctrl and the rest of the simple processor.
// SINGLE_STEP_EN adds the step request input.
interface fetch_decode_ctrl_if #(
  parameter int IW  = 12,
  parameter int RAW = 3,
  parameter int DAW = 4
);
  logic           run;
`ifdef SINGLE_STEP_EN
  logic           step;
`endif
  logic [IW-1:0]  instr_in;
  logic           pc_ld;
  logic [IW-1:0]  ir;
  logic           rf_wr_en;
  logic [RAW-1:0] rf_wr_addr;
  logic [RAW-1:0] rf_rd_addr_a;
  logic [RAW-1:0] rf_rd_addr_b;
  logic           dm_wr_en;
  logic [DAW-1:0] dm_addr;
  logic           wb_sel;
  logic [1:0]     alu_op;
  logic           halted;
  logic [2:0]     state;

  modport master (
`ifdef SINGLE_STEP_EN
    input  step,
`endif
    input  run, instr_in,
    output pc_ld, ir, rf_wr_en, rf_wr_addr, rf_rd_addr_a, rf_rd_addr_b,
           dm_wr_en, dm_addr, wb_sel, alu_op, halted, state
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    output step,
`endif
    output run, instr_in,
    input  pc_ld, ir, rf_wr_en, rf_wr_addr, rf_rd_addr_a, rf_rd_addr_b,
           dm_wr_en, dm_addr, wb_sel, alu_op, halted, state
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode/execute control FSM with fully registered (Moore) outputs.
// Optional SINGLE_STEP_EN: one instruction per synchronised step rising edge.
module fetch_decode_ctrl #(
  parameter int IW  = 12,
  parameter int RAW = 3,
  parameter int DAW = 4
) (
  input  logic clk,
  input  logic rst,
  fetch_decode_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_e;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_e         state_q;
  logic [IW-1:0]  ir_q;
  logic           pc_ld_q, rf_wr_en_q, dm_wr_en_q, wb_sel_q, halted_q;
  logic [RAW-1:0] rf_wr_addr_q, rf_rd_addr_a_q, rf_rd_addr_b_q;
  logic [DAW-1:0] dm_addr_q;
  logic [1:0]     alu_op_q;
  logic [2:0]     op;
  logic           go;
  state_e         exec_next;

  assign op = ir_q[IW-1 -: 3];

`ifdef SINGLE_STEP_EN
  logic [1:0] step_sync_q;
  logic       step_prev_q;
  logic [1:0] busy_q;

  // busy_q tracks the synchroniser so an edge that arrived while the FSM was
  // busy is dropped even if it only surfaces after the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_sync_q <= '0;
      step_prev_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      step_sync_q <= {step_sync_q[0], bus.step};
      step_prev_q <= step_sync_q[1];
      busy_q      <= {busy_q[0], state_q != IDLE};
    end
  end

  assign go        = bus.run & step_sync_q[1] & ~step_prev_q & ~busy_q[1];
  assign exec_next = IDLE;
`else
  assign go        = bus.run;
  assign exec_next = bus.run ? FETCH : IDLE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ir_q           <= '0;
      pc_ld_q        <= 1'b0;
      rf_wr_en_q     <= 1'b0;
      dm_wr_en_q     <= 1'b0;
      wb_sel_q       <= 1'b0;
      halted_q       <= 1'b0;
      rf_wr_addr_q   <= '0;
      rf_rd_addr_a_q <= '0;
      rf_rd_addr_b_q <= '0;
      dm_addr_q      <= '0;
      alu_op_q       <= 2'b00;
    end else begin
      case (state_q)
        IDLE: if (go) state_q <= FETCH;
        FETCH: begin
          ir_q    <= bus.instr_in;
          state_q <= DECODE;
        end
        DECODE: begin
          rf_wr_addr_q   <= ir_q[6 +: RAW];
          // STORE reads its source register through port A
          rf_rd_addr_a_q <= (op == OP_STORE) ? ir_q[6 +: RAW] : ir_q[3 +: RAW];
          rf_rd_addr_b_q <= ir_q[0 +: RAW];
          dm_addr_q      <= ir_q[0 +: DAW];
          wb_sel_q       <= (op == OP_ADD) || (op == OP_SUB);
          alu_op_q       <= (op == OP_ADD) ? 2'b01 : (op == OP_SUB) ? 2'b10 : 2'b00;
          rf_wr_en_q     <= (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
          dm_wr_en_q     <= (op == OP_STORE);
          if (op == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            pc_ld_q  <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          pc_ld_q    <= 1'b0;
          rf_wr_en_q <= 1'b0;
          dm_wr_en_q <= 1'b0;
          state_q    <= exec_next;
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pc_ld        = pc_ld_q;
  assign bus.ir           = ir_q;
  assign bus.rf_wr_en     = rf_wr_en_q;
  assign bus.rf_wr_addr   = rf_wr_addr_q;
  assign bus.rf_rd_addr_a = rf_rd_addr_a_q;
  assign bus.rf_rd_addr_b = rf_rd_addr_b_q;
  assign bus.dm_wr_en     = dm_wr_en_q;
  assign bus.dm_addr      = dm_addr_q;
  assign bus.wb_sel       = wb_sel_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.halted       = halted_q;
  assign bus.state        = state_q;
endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
- Control FSM that sits directly downstream of the 3-bit program counter and instruction memory in the simple processor.
- Latches the instruction addressed by the PC into an instruction register and decodes it into register-file, data-memory and ALU controls.
- Issues a single registered pc_ld pulse per executed instruction, so the PC load always arrives aligned to a clock posedge.

Parameters:
- IW, 12, instruction width.
- RAW, 3, register-file address width (8 registers).
- DAW, 4, data-memory address width (16 words).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start/continue request, level-sensitive.
- instr_in  in  IW  instruction memory read data; async read at the current PC.
- pc_ld  out  1  one-cycle PC advance pulse, drives the PC ld input.
- ir  out  IW  instruction register.
- rf_wr_en  out  1  register-file write enable.
- rf_wr_addr  out  RAW  register-file write address.
- rf_rd_addr_a  out  RAW  register-file read port A address.
- rf_rd_addr_b  out  RAW  register-file read port B address.
- dm_wr_en  out  1  data-memory write enable.
- dm_addr  out  DAW  data-memory address.
- wb_sel  out  1  write-back source: 0 = data memory, 1 = ALU.
- alu_op  out  2  00 none, 01 ADD, 10 SUB.
- halted  out  1  high while in HALT.
- state  out  3  FSM state, for debug.

Behaviour:
- All outputs are registered (Moore).
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4.
- Reset: state=IDLE; ir=0; every other output 0. Reset takes priority in every state, including mid-EXEC; the enables are zero after the reset edge.
- Instruction format: op=ir[11:9]. ALU forms use rd=ir[8:6], ra=ir[5:3], rb=ir[2:0]. Memory forms use r=ir[8:6], addr=ir[3:0], with ir[5:4] ignored.
- Opcodes:
  - 000 LOAD: RF[r] <= DM[addr].
  - 001 STORE: DM[addr] <= RF[r]; the RF read goes on port A.
  - 010 ADD: RF[rd] <= RF[ra] + RF[rb].
  - 011 SUB: RF[rd] <= RF[ra] - RF[rb].
  - 100/101/110: NOP.
  - 111: HALT.
- IDLE: all enables 0. If run=1, go to FETCH on the next edge; otherwise stay.
- FETCH: ir <= instr_in; go to DECODE.
- DECODE: compute the address fields, wb_sel and alu_op from ir. Register the enables so they are high during EXEC only:
  - rf_wr_en for LOAD/ADD/SUB.
  - dm_wr_en for STORE.
  - pc_ld for every opcode except HALT.
  - Then go to EXEC, or to HALT for opcode 111.
- EXEC: lasts exactly one cycle.
  - The enables and pc_ld are high for this cycle only; the PC increments on the edge ending EXEC.
  - On that edge, clear rf_wr_en, dm_wr_en and pc_ld.
  - Next state: FETCH if run=1, else IDLE.
- HALT: halted=1, all enables 0, pc_ld never asserted. Leaves only on rst.
- Throughput: 3 cycles per instruction when run is held high. instr_in in FETCH reflects the PC value after the preceding pc_ld.
- Address fields and alu_op hold their values outside EXEC. Only the enables pulse.
- Deasserting run mid-instruction: the current instruction completes, then the FSM returns to IDLE and the PC is not advanced again.
- PC wrap 7->0 is owned by the PC. This block is unaware of it.

Optional Feature:
- Macro SINGLE_STEP_EN adds input step (1 bit). The input is synchronised to clk and rising-edge detected internally.
- With the macro: IDLE->FETCH requires run=1 AND a detected step edge. EXEC always returns to IDLE, so exactly one instruction executes per step press. A step edge seen outside IDLE is discarded.
- Without the macro: no step port, and behaviour is as described above.

Test Plan:
- Reset: assert rst for 2 cycles in the middle of EXEC of an ADD -> after the reset edge, state=0, pc_ld=0, rf_wr_en=0, ir=0.
- Single LOAD: run=1, instr_in=12'b000_011_00_0101 -> EXEC at cycle 3 after leaving IDLE, with:
  - rf_wr_en=1, rf_wr_addr=3, dm_addr=5, wb_sel=0, pc_ld=1, each for exactly 1 cycle.
- STORE then SUB with run held high:
  - STORE 12'b001_010_00_1111 -> dm_wr_en=1, dm_addr=15, rf_rd_addr_a=2, rf_wr_en=0.
  - SUB 12'b011_001_010_100 -> rf_wr_en=1, rf_wr_addr=1, rf_rd_addr_a=2, rf_rd_addr_b=4, alu_op=10, wb_sel=1.
  - pc_ld pulses are exactly 3 cycles apart.
- HALT: instr_in=12'b111_000_000_000 -> state=4 and halted=1 from the DECODE edge onward. pc_ld stays 0 for 20 cycles even with run=1. rst returns state to 0.
- Run drop: deassert run during DECODE of a NOP (opcode 101) -> pc_ld pulses once with no writes, then state=0, and no further pc_ld occurs.
- SINGLE_STEP_EN build: run=1, with three step pulses spaced 10 cycles apart -> exactly 3 pc_ld pulses. A step pulse applied during EXEC is ignored.
